uart_tx_scheduler: RTL

- Round-robin scheduler that shares one UART transmit line among NUM_REQ byte sources.
- Sequences start, data and stop bits using the oversampled baud tick from the team's baud generator (`UART_baud.baud_sample_tick`).
- Sits between the baud generator and several on-chip producers (debug, status, command response) that need a common TX pin.
- Owns arbitration, the bit-timing state machine and the output shift register.

---
 rtl/uart_tx_scheduler.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin arbiter and UART frame serializer sharing one tx line
module uart_tx_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1,
    localparam int IDW = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           baud_sample_tick,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           tx,
    output logic                           busy,
    output logic [IDW-1:0]                 grant_id,
    output logic                           frame_done
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state, state_next;
    logic [TW-1:0]        tick_cnt, tick_cnt_next;
    logic [BW-1:0]        bit_cnt, bit_cnt_next;
    logic [DATA_BITS-1:0] shreg, shreg_next;
    logic [IDW-1:0]       ptr, ptr_next, sel_idx, grant_id_next;
    logic                 sel_found, bit_end, tx_next, frame_done_next;
    int                   cand;

    // Search starts one past the last grant so a held valid cannot starve the others
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(ptr) + k) % NUM_REQ;
            if (!sel_found && req_valid[IDW'(cand)]) begin
                sel_found = 1'b1;
                sel_idx   = IDW'(cand);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (!rst && state == IDLE && sel_found) begin
            req_ready[sel_idx] = 1'b1;
        end
    end

    assign bit_end = baud_sample_tick && (state != IDLE) && (tick_cnt == TW'(OVERSAMPLE - 1));

    always_comb begin
        state_next      = state;
        tick_cnt_next   = tick_cnt;
        bit_cnt_next    = bit_cnt;
        shreg_next      = shreg;
        ptr_next        = ptr;
        grant_id_next   = grant_id;
        tx_next         = tx;
        frame_done_next = 1'b0;

        if (state != IDLE && baud_sample_tick) begin
            tick_cnt_next = bit_end ? '0 : tick_cnt + TW'(1);
        end

        // tx is registered, so it is driven from the value the next state will present
        case (state)
            IDLE: begin
                tx_next = 1'b1;
                if (sel_found) begin
                    state_next    = START;
                    shreg_next    = req_data[int'(sel_idx) * DATA_BITS +: DATA_BITS];
                    grant_id_next = sel_idx;
                    ptr_next      = sel_idx;
                    tick_cnt_next = '0;
                    tx_next       = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next   = DATA;
                    bit_cnt_next = '0;
                    tx_next      = shreg[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    shreg_next = shreg >> 1;
                    if (bit_cnt == BW'(DATA_BITS - 1)) begin
                        state_next   = STOP;
                        bit_cnt_next = '0;
                        tx_next      = 1'b1;
                    end else begin
                        bit_cnt_next = bit_cnt + BW'(1);
                        tx_next      = shreg[1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (bit_cnt == BW'(STOP_BITS - 1)) begin
                        state_next      = IDLE;
                        bit_cnt_next    = '0;
                        frame_done_next = 1'b1;
                    end else begin
                        bit_cnt_next = bit_cnt + BW'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            ptr        <= IDW'(NUM_REQ - 1);
            grant_id   <= '0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            tick_cnt   <= tick_cnt_next;
            bit_cnt    <= bit_cnt_next;
            shreg      <= shreg_next;
            ptr        <= ptr_next;
            grant_id   <= grant_id_next;
            tx         <= tx_next;
            busy       <= (state_next != IDLE);
            frame_done <= frame_done_next;
        end
    end

endmodule
